// File: rtl/mem_bus_pkg.sv
// Shared types for the IFU/LSU memory bus arbiter: request/response payloads,
// owner identity and arbiter FSM states.
package mem_bus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wen;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_ERR,
    S_DRAIN
  } state_e;

  localparam mem_rsp_t RSP_ERR = '{rdata: 32'h0, err: 1'b1};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between IFU and LSU with a registered last-grant
// pointer; the pointer only moves when the caller commits the pick.
module rr_arb2
  import mem_bus_pkg::*;
#(
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic update,
  output logic pick_lsu
);

  localparam owner_e LAST_RESET = LSU_FIRST ? OWN_IFU : OWN_LSU;

  owner_e last;
  owner_e pick;

  always_comb begin
    pick = OWN_IFU;
    if (req_ifu && req_lsu) begin
      pick = (last == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (req_lsu) begin
      pick = OWN_LSU;
    end
  end

  assign pick_lsu = (pick == OWN_LSU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= LAST_RESET;
    end else if (update) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory slave port between IFU and LSU: one outstanding transaction,
// ownership held until the response handshake, watchdog-generated error response.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          LSU_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [68:0] ifu_req,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [32:0] ifu_rsp,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [68:0] lsu_req,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [32:0] lsu_rsp,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [68:0] mem_req,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [32:0] mem_rsp,
  output logic        busy
);

  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  state_e         state;
  owner_e         owner;
  logic [WDW-1:0] wdog;

  mem_req_t own_req;
  logic     own_rsp_ready;
  logic     any_req;
  logic     pick_lsu;

  assign any_req       = ifu_req_valid | lsu_req_valid;
  assign own_req       = (owner == OWN_LSU) ? mem_req_t'(lsu_req) : mem_req_t'(ifu_req);
  assign own_rsp_ready = (owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  rr_arb2 #(.LSU_FIRST(LSU_FIRST)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_ifu  (ifu_req_valid),
    .req_lsu  (lsu_req_valid),
    .update   ((state == S_IDLE) && any_req),
    .pick_lsu (pick_lsu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      owner <= OWN_IFU;
      wdog  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner <= pick_lsu ? OWN_LSU : OWN_IFU;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            wdog  <= '0;
            state <= S_RSP;
          end
        end
        S_RSP: begin
          // A response landing in the expiry cycle still completes normally.
          if (mem_rsp_valid && own_rsp_ready) begin
            state <= S_IDLE;
          end else begin
            if (wdog != '1) wdog <= wdog + WDW'(1);
            if ((TIMEOUT != 0) && (wdog == WD_LAST)) state <= S_ERR;
          end
        end
        S_ERR: begin
          if (own_rsp_ready) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (mem_rsp_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rsp       = '0;
    lsu_rsp       = '0;
    mem_req_valid = 1'b0;
    mem_req       = '0;
    mem_rsp_ready = 1'b0;
    case (state)
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req       = own_req;
        if (owner == OWN_LSU) lsu_req_ready = mem_req_ready;
        else                  ifu_req_ready = mem_req_ready;
      end
      S_RSP: begin
        mem_rsp_ready = own_rsp_ready;
        if (owner == OWN_LSU) begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rsp       = mem_rsp;
        end else begin
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rsp       = mem_rsp;
        end
      end
      S_ERR: begin
        if (owner == OWN_LSU) begin
          lsu_rsp_valid = 1'b1;
          lsu_rsp       = RSP_ERR;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rsp       = RSP_ERR;
        end
      end
      S_DRAIN: mem_rsp_ready = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed per-cycle vector bench for mem_bus_arbiter (TIMEOUT=8, LSU_FIRST=1)
// plus a bounded-latency hand sequence.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic        busy;
  logic [68:0] ifu_req, lsu_req, mem_req;
  logic [32:0] ifu_rsp, lsu_rsp, mem_rsp;

  localparam mem_req_t IFU_REQ = '{addr: 32'h8000_0000, wdata: 32'h0, wstrb: 4'h0, wen: 1'b0};
  localparam mem_req_t LSU_REQ = '{addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF, wstrb: 4'b0011, wen: 1'b1};
  localparam mem_rsp_t MEM_RSP = '{rdata: 32'h0000_0413, err: 1'b0};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(8), .LSU_FIRST(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req       (ifu_req),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp       (ifu_rsp),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req       (lsu_req),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp       (lsu_rsp),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req       (mem_req),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp       (mem_rsp),
    .busy          (busy)
  );

  // in_v : {rst, ifu_req_valid, lsu_req_valid, mem_req_ready, mem_rsp_valid, ifu_rsp_ready, lsu_rsp_ready}
  // out_v: {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, busy}
  // msrc : 0 zero, 1 IFU payload, 2 LSU payload; irsp/lrsp: 0 zero, 1 slave rsp, 2 error rsp
  typedef struct {
    logic [6:0] in_v;
    logic [6:0] out_v;
    logic [1:0] msrc;
    logic [1:0] irsp;
    logic [1:0] lrsp;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [6:0] i, input logic [6:0] o,
                     input logic [1:0] m, input logic [1:0] ir, input logic [1:0] lr);
    vec_t v;
    v.in_v = i; v.out_v = o; v.msrc = m; v.irsp = ir; v.lrsp = lr;
    vq.push_back(v);
  endtask

  task automatic rep(input int n, input logic [6:0] i, input logic [6:0] o,
                     input logic [1:0] m, input logic [1:0] ir, input logic [1:0] lr);
    for (int k = 0; k < n; k++) add(i, o, m, ir, lr);
  endtask

  function automatic logic [32:0] exp_rsp(input logic [1:0] code);
    case (code)
      2'd1:    return MEM_RSP;
      2'd2:    return RSP_ERR;
      default: return '0;
    endcase
  endfunction

  function automatic logic [68:0] exp_req(input logic [1:0] code);
    case (code)
      2'd1:    return IFU_REQ;
      2'd2:    return LSU_REQ;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [141:0] got, input logic [141:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    logic [141:0] got_all, exp_all;
    int  cnt;
    bit  seen;
    logic rdy;

    ifu_req = IFU_REQ;
    lsu_req = LSU_REQ;
    mem_rsp = MEM_RSP;
    {rst, ifu_req_valid, lsu_req_valid, mem_req_ready, mem_rsp_valid, ifu_rsp_ready, lsu_rsp_ready} = 7'b0111111;

    // reset state with all inputs active
    add(7'b0111111, 7'b0000000, 0, 0, 0);
    // IFU-only read, slave answers one cycle after accept
    add(7'b1100000, 7'b0000000, 0, 0, 0);
    add(7'b1101000, 7'b1010001, 1, 0, 0);
    add(7'b1000010, 7'b0001001, 0, 1, 0);
    add(7'b1000110, 7'b0001101, 0, 1, 0);
    add(7'b1000000, 7'b0000000, 0, 0, 0);
    // both requesting after reset: LSU, IFU, LSU with a bubble between
    add(7'b0000000, 7'b0000000, 0, 0, 0);
    add(7'b1110000, 7'b0000000, 0, 0, 0);
    add(7'b1111000, 7'b0110001, 2, 0, 0);
    add(7'b1110101, 7'b0001011, 0, 0, 1);
    add(7'b1110000, 7'b0000000, 0, 0, 0);
    add(7'b1111000, 7'b1010001, 1, 0, 0);
    add(7'b1110110, 7'b0001101, 0, 1, 0);
    add(7'b1110000, 7'b0000000, 0, 0, 0);
    add(7'b1111000, 7'b0110001, 2, 0, 0);
    add(7'b1000101, 7'b0001011, 0, 0, 1);
    add(7'b1000000, 7'b0000000, 0, 0, 0);
    // LSU write stalled by slave, then owner stalls the response with IFU waiting
    add(7'b1010000, 7'b0000000, 0, 0, 0);
    rep(5, 7'b1010000, 7'b0010001, 2, 0, 0);
    add(7'b1011000, 7'b0110001, 2, 0, 0);
    rep(4, 7'b1100100, 7'b0000011, 0, 0, 1);
    add(7'b1100101, 7'b0001011, 0, 0, 1);
    add(7'b1100000, 7'b0000000, 0, 0, 0);
    add(7'b1101000, 7'b1010001, 1, 0, 0);
    add(7'b1000110, 7'b0001101, 0, 1, 0);
    add(7'b1000000, 7'b0000000, 0, 0, 0);
    // LSU watchdog expiry, error response, late slave response drained
    add(7'b1010000, 7'b0000000, 0, 0, 0);
    add(7'b1011000, 7'b0110001, 2, 0, 0);
    rep(8, 7'b1000001, 7'b0001001, 0, 0, 1);
    add(7'b1000000, 7'b0000011, 0, 0, 2);
    add(7'b1000001, 7'b0000011, 0, 0, 2);
    add(7'b1000000, 7'b0001001, 0, 0, 0);
    add(7'b1000100, 7'b0001001, 0, 0, 0);
    add(7'b1000000, 7'b0000000, 0, 0, 0);
    // IFU response arriving in the expiry cycle wins over the error
    add(7'b1100000, 7'b0000000, 0, 0, 0);
    add(7'b1101000, 7'b1010001, 1, 0, 0);
    rep(7, 7'b1000000, 7'b0000001, 0, 1, 0);
    add(7'b1000110, 7'b0001101, 0, 1, 0);
    add(7'b1000000, 7'b0000000, 0, 0, 0);
    // reset mid-response, then conflict re-arbitrated from reset priority
    add(7'b1010000, 7'b0000000, 0, 0, 0);
    add(7'b1011000, 7'b0110001, 2, 0, 0);
    add(7'b1000001, 7'b0001001, 0, 0, 1);
    add(7'b0111111, 7'b0000000, 0, 0, 0);
    add(7'b1110000, 7'b0000000, 0, 0, 0);
    add(7'b1111000, 7'b0110001, 2, 0, 0);
    add(7'b1000101, 7'b0001011, 0, 0, 1);
    add(7'b1000000, 7'b0000000, 0, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      {rst, ifu_req_valid, lsu_req_valid, mem_req_ready, mem_rsp_valid, ifu_rsp_ready, lsu_rsp_ready} = vq[i].in_v;
      #1;
      got_all = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
                 lsu_rsp_valid, busy, mem_req, ifu_rsp, lsu_rsp};
      exp_all = {vq[i].out_v, exp_req(vq[i].msrc), exp_rsp(vq[i].irsp), exp_rsp(vq[i].lrsp)};
      check($sformatf("vec%0d", i), got_all, exp_all);
    end

    // always-ready slave: IFU response visible two cycles after request
    @(negedge clk);
    {rst, ifu_req_valid, lsu_req_valid, mem_req_ready, mem_rsp_valid, ifu_rsp_ready, lsu_rsp_ready} = 7'b1101110;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 20 && !seen) begin
      #1;
      if (ifu_rsp_valid) begin
        seen = 1'b1;
      end else begin
        rdy = ifu_req_ready;
        @(negedge clk);
        if (rdy) ifu_req_valid = 1'b0;
        cnt++;
      end
    end
    check("rsp_latency", 142'({seen, 8'(cnt)}), 142'({1'b1, 8'd2}));
    check("rsp_payload", 142'(ifu_rsp), 142'(MEM_RSP));
    @(negedge clk);
    {rst, ifu_req_valid, lsu_req_valid, mem_req_ready, mem_rsp_valid, ifu_rsp_ready, lsu_rsp_ready} = 7'b1000000;
    #1;
    check("idle_after", 142'(busy), 142'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
